// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle spacing between rising edges of an asynchronous step
// pulse train, strobing each interval and flagging a stall when edges stop.
module pulse_period_meter #(
    parameter int unsigned     COUNT_BITS = 32,
    parameter longint unsigned TIMEOUT    = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  inpulse,
    output logic [COUNT_BITS-1:0] period,
    output logic                  period_valid,
    output logic                  stalled,
    output logic [COUNT_BITS-1:0] pulse_count
);

    // S_IDLE: disabled | S_ARMED: waiting for a reference edge | S_MEAS: timing an interval
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_MEAS  = 2'd2
    } state_t;

    localparam logic [COUNT_BITS-1:0] TIMEOUT_C = COUNT_BITS'(TIMEOUT);
    localparam logic [COUNT_BITS-1:0] ONE_C     = COUNT_BITS'(1);

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_prev;
    logic                  w_rise;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [COUNT_BITS-1:0] r_cnt;
    logic [COUNT_BITS-1:0] w_cnt_nxt;
    logic [COUNT_BITS-1:0] w_cnt_inc;
    logic [COUNT_BITS-1:0] r_period;
    logic [COUNT_BITS-1:0] w_period_nxt;
    logic [COUNT_BITS-1:0] r_pcount;
    logic [COUNT_BITS-1:0] w_pcount_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;
    logic                  r_stalled;
    logic                  w_stalled_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= inpulse;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_rise    = r_sync2 & ~r_prev;
    assign w_cnt_inc = r_cnt + ONE_C;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_pcount  <= '0;
            r_valid   <= 1'b0;
            r_stalled <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_period  <= w_period_nxt;
            r_pcount  <= w_pcount_nxt;
            r_valid   <= w_valid_nxt;
            r_stalled <= w_stalled_nxt;
        end
    end

    // Disable overrides everything, including a coincident edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_period_nxt  = r_period;
        w_pcount_nxt  = r_pcount;
        w_valid_nxt   = 1'b0;
        w_stalled_nxt = r_stalled;
        if (!enable) begin
            w_state_nxt   = S_IDLE;
            w_cnt_nxt     = '0;
            w_stalled_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt   = S_ARMED;
                    w_cnt_nxt     = '0;
                    w_stalled_nxt = 1'b0;
                end
                S_ARMED: begin
                    if (w_rise) begin
                        w_state_nxt   = S_MEAS;
                        w_cnt_nxt     = '0;
                        w_stalled_nxt = 1'b0;
                        w_pcount_nxt  = r_pcount + ONE_C;
                    end
                end
                S_MEAS: begin
                    if (w_rise) begin
                        w_period_nxt = w_cnt_inc;
                        w_valid_nxt  = 1'b1;
                        w_cnt_nxt    = '0;
                        w_pcount_nxt = r_pcount + ONE_C;
                    end else if (w_cnt_inc == TIMEOUT_C) begin
                        w_state_nxt   = S_ARMED;
                        w_cnt_nxt     = '0;
                        w_stalled_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = '0;
                    w_stalled_nxt = 1'b0;
                end
            endcase
        end
    end

    assign period       = r_period;
    assign period_valid = r_valid;
    assign stalled      = r_stalled;
    assign pulse_count  = r_pcount;

endmodule
